// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, PC step and fetch entry layout for the fetch front end
package fetch_unit_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  localparam logic [INST_W-1:0] ZeroWord = '0;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous first-word fall-through FIFO with clear, used as the prefetch buffer
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = clear ? '0 : push ? wr_q + AW'(1) : wr_q;
    rd_d = clear ? '0 : pop ? rd_q + AW'(1) : rd_q;
    cnt_d = clear ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential fetch with credit-limited ROM requests, prefetch buffer and flush-drop tracking
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_rvalid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              err_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_cnt;
  logic [CW:0] in_use;
  logic [EW-1:0] head;
  logic err_q, err_d, fifo_full, fifo_empty, issue, resp, push, pop;
  // Credit covers both buffered and in-flight words so the FIFO can never overflow
  always_comb begin
    tgt = flush_pc_i & ~ADDR_W'(3);
    in_use = {1'b0, fifo_cnt} + {1'b0, out_q};
    resp = rom_rvalid_i && out_q != '0;
    issue = !rst && !flush_i && !fifo_full && in_use < (CW+1)'(DEPTH);
    push = resp && drop_q == '0 && !flush_i;
    pop = !fifo_empty && id_ready_i && !flush_i;
    pc_d = flush_i ? tgt : issue ? pc_q + ADDR_W'(PC_INC) : pc_q;
    resp_pc_d = flush_i ? tgt : push ? resp_pc_q + ADDR_W'(PC_INC) : resp_pc_q;
    out_d = out_q + CW'(issue) - CW'(resp);
    drop_d = flush_i ? out_q - CW'(resp) : (resp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    err_d = err_q || (rom_rvalid_i && out_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      err_q <= err_d;
    end
  end
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_i),
    .din   ({resp_pc_q, rom_data_i}),
    .dout  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign rom_ce_o = issue;
  assign rom_addr_o = pc_q;
  assign id_valid_o = !rst && !fifo_empty;
  assign id_pc_o = rst ? '0 : head[EW-1:DATA_W];
  assign id_inst_o = rst ? DATA_W'(ZeroWord) : head[DATA_W-1:0];
  assign err_o = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard plus vector-table bench for fetch_unit with an in-order variable-latency ROM model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic rom_ce_o, rom_rvalid_i = 1'b0, id_valid_o, id_ready_i = 1'b0, flush_i = 1'b0, err_o;
  logic [31:0] rom_addr_o, rom_data_i = '0, id_pc_o, id_inst_o, flush_pc_i = '0;
  logic w_ce, w_rvalid = 1'b0, w_valid, w_ready = 1'b1, w_flush = 1'b0, w_err;
  logic [31:0] w_addr, w_data = '0, w_pc, w_inst, w_fpc = '0;
  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
    .rom_rvalid_i(rom_rvalid_i), .rom_data_i(rom_data_i), .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_ready_i(id_ready_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .err_o(err_o));
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .rom_ce_o(w_ce), .rom_addr_o(w_addr),
    .rom_rvalid_i(w_rvalid), .rom_data_i(w_data), .id_valid_o(w_valid),
    .id_pc_o(w_pc), .id_inst_o(w_inst), .id_ready_i(w_ready),
    .flush_i(w_flush), .flush_pc_i(w_fpc), .err_o(w_err));
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic rdy; logic ce; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;
  req_t rom_q[$];
  fetch_entry_t sb[$];
  logic [31:0] got_pcs[$], w_addrs[$], w_pcs[$], w_insts[$];
  int cyc = 0, lat = 1, dead = 0, n_tests = 0, n_fail = 0;
  logic [31:0] exp_pc = '0, s_addr, s_pc, w_prev_addr = '0;
  logic s_ce, s_valid, s_err, s_rv, w_prev = 1'b0;
  vec_t tbl[10];
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask
  // One clock: drive inputs at negedge, sample and score 1 time unit later, commit at posedge
  task automatic tick(input logic r, input logic rdy, input logic fl, input logic [31:0] fpc, input logic frv);
    logic rv, e_ce, e_valid;
    logic [31:0] ra;
    int out_m;
    req_t rq;
    fetch_entry_t fe;
    @(negedge clk);
    rst = r;
    rv = 1'b0;
    ra = '0;
    out_m = rom_q.size();
    if (!r && rom_q.size() > 0 && rom_q[0].due <= cyc) begin
      rq = rom_q.pop_front();
      rv = 1'b1;
      ra = rq.addr;
    end
    rom_rvalid_i = rv | frv;
    rom_data_i = rv ? word(ra) : 32'hDEAD_BEEF;
    id_ready_i = rdy;
    flush_i = fl;
    flush_pc_i = fpc;
    w_rvalid = w_prev && !r;
    w_data = word(w_prev_addr);
    #1;
    s_ce = rom_ce_o; s_addr = rom_addr_o; s_valid = id_valid_o; s_pc = id_pc_o; s_err = err_o; s_rv = rv;
    if (r) begin
      chk("rst_ce", rom_ce_o, 0);
      chk("rst_valid", id_valid_o, 0);
      chk("rst_pc", id_pc_o, 0);
      chk("rst_inst", id_inst_o, 0);
      rom_q.delete(); sb.delete(); got_pcs.delete();
      w_addrs.delete(); w_pcs.delete(); w_insts.delete();
      dead = 0;
      exp_pc = '0;
    end else begin
      e_ce = !fl && (sb.size() + dead < DEPTH);
      e_valid = sb.size() > out_m - dead;
      chk("ce", rom_ce_o, e_ce);
      chk("valid", id_valid_o, e_valid);
      if (rom_ce_o && e_ce) chk("addr", rom_addr_o, exp_pc);
      if (id_valid_o && e_valid) begin
        chk("head_pc", id_pc_o, sb[0].pc);
        chk("head_inst", id_inst_o, sb[0].inst);
      end
      if (rv && dead > 0) dead--;
      if (e_valid && rdy && !fl) begin
        fe = sb.pop_front();
        got_pcs.push_back(fe.pc);
      end
      if (rom_ce_o) rom_q.push_back('{rom_addr_o, cyc + lat});
      if (e_ce) begin
        sb.push_back('{exp_pc, word(exp_pc)});
        exp_pc += 32'd4;
      end
      if (fl) begin
        sb.delete();
        dead = rom_q.size();
        exp_pc = fpc & ~32'h3;
      end
      if (w_ce) w_addrs.push_back(w_addr);
      if (w_valid) begin
        w_pcs.push_back(w_pc);
        w_insts.push_back(w_inst);
      end
    end
    w_prev = w_ce;
    w_prev_addr = w_addr;
    @(posedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFFC; wexp[1] = 32'h0; wexp[2] = 32'h4;
    tbl[0] = '{0, 1, 32'h00, 0, 32'h0};
    tbl[1] = '{0, 1, 32'h04, 0, 32'h0};
    tbl[2] = '{0, 1, 32'h08, 1, 32'h0};
    tbl[3] = '{0, 1, 32'h0C, 1, 32'h0};
    tbl[4] = '{0, 0, 32'h00, 1, 32'h0};
    tbl[5] = '{1, 0, 32'h00, 1, 32'h0};
    tbl[6] = '{1, 1, 32'h10, 1, 32'h4};
    tbl[7] = '{1, 1, 32'h14, 1, 32'h8};
    tbl[8] = '{1, 1, 32'h18, 1, 32'hC};
    tbl[9] = '{1, 1, 32'h1C, 1, 32'h10};
    lat = 1;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      tick(0, 1, 0, 0, 0);
      chk("t1_addr", s_addr, 32'(4 * i));
      chk("t1_valid", s_valid, i >= 2);
      if (i >= 2) chk("t1_pc", s_pc, 32'(4 * (i - 2)));
    end
    chk("wrap_count", (w_addrs.size() >= 3 && w_pcs.size() >= 3), 1);
    if (w_addrs.size() >= 3 && w_pcs.size() >= 3)
      for (int k = 0; k < 3; k++) begin
        chk("wrap_addr", w_addrs[k], wexp[k]);
        chk("wrap_pc", w_pcs[k], wexp[k]);
        chk("wrap_inst", w_insts[k], word(wexp[k]));
      end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(0, tbl[i].rdy, 0, 0, 0);
      chk("t2_ce", s_ce, tbl[i].ce);
      if (tbl[i].ce) chk("t2_addr", s_addr, tbl[i].addr);
      chk("t2_valid", s_valid, tbl[i].valid);
      if (tbl[i].valid) chk("t2_pc", s_pc, tbl[i].pc);
    end
    lat = 4;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 32'h100, 0);
    chk("t3_flush_ce", s_ce, 0);
    got_pcs.delete();
    for (int i = 0; i < 12; i++) tick(0, 1, 0, 0, 0);
    chk("t3_npops", got_pcs.size() >= 2, 1);
    if (got_pcs.size() >= 2) begin
      chk("t3_first", got_pcs[0], 32'h100);
      chk("t3_second", got_pcs[1], 32'h104);
    end
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 32'h203, 0);
    chk("t4_coincident", {s_rv, s_valid}, 2'b11);
    got_pcs.delete();
    tick(0, 1, 0, 0, 0);
    chk("t4_empty", s_valid, 0);
    chk("t4_ce", s_ce, 1);
    chk("t4_addr", s_addr, 32'h200);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
    chk("t4_npops", got_pcs.size() >= 1, 1);
    if (got_pcs.size() >= 1) chk("t4_first", got_pcs[0], 32'h200);
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);
    chk("t6_err_pre", s_err, 0);
    tick(0, 0, 0, 0, 1);
    chk("t6_err_same", s_err, 0);
    tick(0, 0, 0, 0, 0);
    chk("t6_err_set", s_err, 1);
    chk("t6_head", s_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 0, 0, 0);
      chk("t6_err_hold", s_err, 1);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("t6_err_rst", s_err, 0);
    tick(0, 0, 0, 0, 0);
    chk("t6_err_clr", s_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
